// File: rtl/pipelined_flag_alu_if.sv
// Handshake bus for pipelined_flag_alu: operation request in, registered result,
// per-result flags and architectural NZCV out.
interface pipelined_flag_alu_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       exe_cmd;
   logic             s_bit;
   logic [WIDTH-1:0] val1;
   logic [WIDTH-1:0] val2;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] alu_res;
   logic [3:0]       res_flags;
   logic [3:0]       status_bits;
   logic             busy;

   modport master (
      output in_valid, exe_cmd, s_bit, val1, val2, out_ready,
      input  in_ready, out_valid, alu_res, res_flags, status_bits, busy
   );

   modport slave (
      input  in_valid, exe_cmd, s_bit, val1, val2, out_ready,
      output in_ready, out_valid, alu_res, res_flags, status_bits, busy
   );
endinterface

// File: rtl/pipelined_flag_alu.sv
// Registered execute-stage ALU with NZCV status register and valid/ready handshakes.
// Define ALU_MUL_EN to build the iterative shift-add multiplier for cmd 10.
module pipelined_flag_alu #(
   parameter int         WIDTH       = 32,
   parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
   input logic                 clk,
   input logic                 rst_n,
   pipelined_flag_alu_if.slave bus
);
   localparam logic [3:0] CMD_MOV = 4'd1;
   localparam logic [3:0] CMD_ADD = 4'd2;
   localparam logic [3:0] CMD_ADC = 4'd3;
   localparam logic [3:0] CMD_SUB = 4'd4;
   localparam logic [3:0] CMD_SBC = 4'd5;
   localparam logic [3:0] CMD_AND = 4'd6;
   localparam logic [3:0] CMD_ORR = 4'd7;
   localparam logic [3:0] CMD_EOR = 4'd8;
   localparam logic [3:0] CMD_MVN = 4'd9;

   logic             valid;
   logic [WIDTH-1:0] result;
   logic [3:0]       flags;
   logic [3:0]       status;
   logic             in_ready;
   logic             accept;
   logic             consume;
   logic             idle;
   logic             is_mul;

   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] single_res;
   logic [WIDTH:0]   sum;
   logic             carry_in;
   logic             is_arith;
   logic             is_defined;
   logic [3:0]       single_flags;

`ifdef ALU_MUL_EN
   localparam logic [3:0]       CMD_MUL = 4'd10;
   localparam logic [WIDTH-1:0] LAST    = WIDTH'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] product;
   logic [WIDTH-1:0] count;
   logic             mul_s;

   assign is_mul   = (bus.exe_cmd == CMD_MUL);
   assign idle     = (state == IDLE);
   assign bus.busy = (state != IDLE);
`else
   assign is_mul   = 1'b0;
   assign idle     = 1'b1;
   assign bus.busy = 1'b0;
`endif

   assign in_ready        = idle && (!valid || bus.out_ready);
   assign accept          = bus.in_valid && in_ready;
   assign consume         = valid && bus.out_ready;
   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = valid;
   assign bus.alu_res     = result;
   assign bus.res_flags   = flags;
   assign bus.status_bits = status;

   // Subtraction is a + ~b + cin so one adder serves all four arithmetic ops.
   always_comb begin
      op_b       = bus.val2;
      carry_in   = 1'b0;
      is_arith   = 1'b0;
      is_defined = 1'b1;
      case (bus.exe_cmd)
         CMD_ADD: is_arith = 1'b1;
         CMD_ADC: begin
            is_arith = 1'b1;
            carry_in = status[1];
         end
         CMD_SUB: begin
            is_arith = 1'b1;
            op_b     = ~bus.val2;
            carry_in = 1'b1;
         end
         CMD_SBC: begin
            is_arith = 1'b1;
            op_b     = ~bus.val2;
            carry_in = status[1];
         end
         CMD_MOV, CMD_MVN, CMD_AND, CMD_ORR, CMD_EOR: is_arith = 1'b0;
         default: is_defined = 1'b0;
      endcase

      sum = {1'b0, bus.val1} + {1'b0, op_b} + {{WIDTH{1'b0}}, carry_in};

      case (bus.exe_cmd)
         CMD_MOV: single_res = bus.val2;
         CMD_MVN: single_res = ~bus.val2;
         CMD_AND: single_res = bus.val1 & bus.val2;
         CMD_ORR: single_res = bus.val1 | bus.val2;
         CMD_EOR: single_res = bus.val1 ^ bus.val2;
         CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: single_res = sum[WIDTH-1:0];
         default: single_res = '0;
      endcase

      if (!is_defined) begin
         single_flags = 4'b0000;
      end else if (is_arith) begin
         single_flags = {single_res[WIDTH-1], single_res == '0, sum[WIDTH],
                         (bus.val1[WIDTH-1] == op_b[WIDTH-1]) &&
                         (single_res[WIDTH-1] != bus.val1[WIDTH-1])};
      end else begin
         single_flags = {single_res[WIDTH-1], single_res == '0, status[1:0]};
      end
   end

   // Logical ops carry the current C,V in single_flags, so committing them whole is correct.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid   <= 1'b0;
         result  <= '0;
         flags   <= 4'b0000;
         status  <= RESET_FLAGS;
`ifdef ALU_MUL_EN
         state   <= IDLE;
         mcand   <= '0;
         mplier  <= '0;
         product <= '0;
         count   <= '0;
         mul_s   <= 1'b0;
`endif
      end else begin
         if (consume) valid <= 1'b0;
         if (accept && !is_mul) begin
            valid  <= 1'b1;
            result <= single_res;
            flags  <= single_flags;
            if (bus.s_bit && is_defined) status <= single_flags;
         end
`ifdef ALU_MUL_EN
         case (state)
            IDLE: begin
               if (accept && is_mul) begin
                  mcand   <= bus.val1;
                  mplier  <= bus.val2;
                  product <= '0;
                  count   <= '0;
                  mul_s   <= bus.s_bit;
                  state   <= MUL;
               end
            end
            MUL: begin
               if (mplier[0]) product <= product + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count + WIDTH'(1);
               if (count == LAST) state <= DONE;
            end
            DONE: begin
               valid  <= 1'b1;
               result <= product;
               flags  <= {product[WIDTH-1], product == '0, status[1:0]};
               if (mul_s) status <= {product[WIDTH-1], product == '0, status[1:0]};
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
`endif
      end
   end
endmodule

// File: tb/tb_pipelined_flag_alu.sv
// Self-checking bench for pipelined_flag_alu: directed cases plus randomized traffic
// against an arithmetic reference model with a cycle-level handshake model.
module tb_pipelined_flag_alu;
   localparam int W = 32;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;
`ifdef ALU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   compared;
   int   mismatched;

   logic        exp_valid;
   logic [31:0] exp_res;
   logic [3:0]  exp_flags;
   logic [3:0]  exp_status;
   int          mul_left;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic        mul_s;

   pipelined_flag_alu_if #(.WIDTH(W)) bus ();

   pipelined_flag_alu #(.WIDTH(W), .RESET_FLAGS(4'b0000)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // ARM-style result and NZCV computed with plain signed/unsigned 64-bit arithmetic.
   function automatic void ref_alu(input logic [3:0] cmd, input logic [31:0] a,
                                   input logic [31:0] b, input logic [3:0] st,
                                   output logic [31:0] r, output logic [3:0] f,
                                   output logic def);
      longint ua, ub, sa, sb, full, sfull, cin;
      logic   cf, vf;
      ua  = longint'(a);
      ub  = longint'(b);
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      cf  = st[1];
      vf  = st[0];
      def = 1'b1;
      r   = 32'd0;
      cin = 0;
      case (cmd)
         4'd1: r = b;
         4'd9: r = ~b;
         4'd6: r = a & b;
         4'd7: r = a | b;
         4'd8: r = a ^ b;
         4'd2, 4'd3: begin
            if (cmd == 4'd3) cin = st[1];
            full  = ua + ub + cin;
            sfull = sa + sb + cin;
            r     = full[31:0];
            cf    = (full > 64'sd4294967295);
            vf    = (sfull > SMAX) || (sfull < SMIN);
         end
         4'd4, 4'd5: begin
            if (cmd == 4'd5) cin = 1 - longint'(st[1]);
            full  = ua - ub - cin;
            sfull = sa - sb - cin;
            r     = full[31:0];
            cf    = (full >= 0);
            vf    = (sfull > SMAX) || (sfull < SMIN);
         end
         default: def = 1'b0;
      endcase
      f = def ? {r[31], r == 32'd0, cf, vf} : 4'b0000;
   endfunction

   task automatic checkOutput(input string tag);
      compare({tag, ".out_valid"}, 64'(bus.out_valid), 64'(exp_valid));
      compare({tag, ".alu_res"}, 64'(bus.alu_res), 64'(exp_res));
      compare({tag, ".res_flags"}, 64'(bus.res_flags), 64'(exp_flags));
      compare({tag, ".status_bits"}, 64'(bus.status_bits), 64'(exp_status));
      compare({tag, ".busy"}, 64'(bus.busy), 64'(mul_left > 0));
   endtask

   // One clock step: drive inputs at posedge+1, check in_ready, advance the model, check outputs.
   task automatic applyStimulus(input string tag, input logic iv, input logic [3:0] cmd,
                                input logic s, input logic [31:0] a, input logic [31:0] b,
                                input logic ordy);
      logic        exp_ready;
      logic [31:0] r;
      logic [3:0]  f;
      logic        def;
      longint unsigned prod;
      bus.in_valid  = iv;
      bus.exe_cmd   = cmd;
      bus.s_bit     = s;
      bus.val1      = a;
      bus.val2      = b;
      bus.out_ready = ordy;
      #1;
      exp_ready = (mul_left == 0) && (!exp_valid || ordy);
      compare({tag, ".in_ready"}, 64'(bus.in_ready), 64'(exp_ready));
      @(posedge clk);
      if (exp_valid && ordy) exp_valid = 1'b0;
      if (mul_left > 0) begin
         mul_left--;
         if (mul_left == 0) begin
            prod      = longint'(mul_a) * longint'(mul_b);
            exp_res   = prod[31:0];
            exp_flags = {exp_res[31], exp_res == 32'd0, exp_status[1:0]};
            if (mul_s) exp_status = exp_flags;
            exp_valid = 1'b1;
         end
      end else if (iv && exp_ready) begin
         if (MUL_EN && cmd == 4'd10) begin
            mul_left = W + 1;
            mul_a    = a;
            mul_b    = b;
            mul_s    = s;
         end else begin
            ref_alu(cmd, a, b, exp_status, r, f, def);
            exp_res   = r;
            exp_flags = f;
            exp_valid = 1'b1;
            if (s && def) exp_status = f;
         end
      end
      #1;
      checkOutput(tag);
   endtask

   // Enters at posedge+1, pulls reset low away from any edge, returns at posedge+1.
   task automatic doReset(input string tag);
      rst_n = 1'b0;
      #1;
      exp_valid  = 1'b0;
      exp_res    = 32'd0;
      exp_flags  = 4'b0000;
      exp_status = 4'b0000;
      mul_left   = 0;
      checkOutput(tag);
      compare({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] edge_vals [4];
      logic [3:0]  cmd;
      logic [31:0] a;
      logic [31:0] b;
      int          n;
      edge_vals = '{32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

      compared      = 0;
      mismatched    = 0;
      exp_valid     = 1'b0;
      exp_res       = 32'd0;
      exp_flags     = 4'b0000;
      exp_status    = 4'b0000;
      mul_left      = 0;
      mul_a         = 32'd0;
      mul_b         = 32'd0;
      mul_s         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.exe_cmd   = 4'd0;
      bus.s_bit     = 1'b0;
      bus.val1      = 32'd0;
      bus.val2      = 32'd0;
      bus.out_ready = 1'b1;
      rst_n         = 1'b1;
      #2 rst_n = 1'b0;
      #2;
      checkOutput("reset");
      compare("reset.in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;

      applyStimulus("add_ovf", 1'b1, 4'd2, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
      compare("add_ovf.res_const", 64'(bus.alu_res), 64'h8000_0000);
      compare("add_ovf.status_const", 64'(bus.status_bits), 64'b1001);

      applyStimulus("sub_eq", 1'b1, 4'd4, 1'b1, 32'd5, 32'd5, 1'b1);
      compare("sub_eq.status_const", 64'(bus.status_bits), 64'b0110);
      applyStimulus("adc_nos", 1'b1, 4'd3, 1'b0, 32'd1, 32'd1, 1'b1);
      compare("adc_nos.res_const", 64'(bus.alu_res), 64'd3);
      compare("adc_nos.status_const", 64'(bus.status_bits), 64'b0110);

      applyStimulus("sub_neg", 1'b1, 4'd4, 1'b1, 32'd0, 32'd1, 1'b1);
      compare("sub_neg.status_const", 64'(bus.status_bits), 64'b1000);
      applyStimulus("mvn_keep", 1'b1, 4'd9, 1'b1, 32'd0, 32'd0, 1'b1);
      compare("mvn_keep.res_const", 64'(bus.alu_res), 64'hFFFF_FFFF);
      compare("mvn_keep.status_const", 64'(bus.status_bits), 64'b1000);

      applyStimulus("bp_add", 1'b1, 4'd2, 1'b0, 32'd1, 32'd2, 1'b1);
      applyStimulus("bp_hold1", 1'b1, 4'd7, 1'b0, 32'd4, 32'd8, 1'b0);
      applyStimulus("bp_hold2", 1'b1, 4'd7, 1'b0, 32'd4, 32'd8, 1'b0);
      compare("bp_hold.res_const", 64'(bus.alu_res), 64'd3);
      applyStimulus("bp_release", 1'b1, 4'd7, 1'b0, 32'd4, 32'd8, 1'b1);
      compare("bp_release.res_const", 64'(bus.alu_res), 64'd12);
      applyStimulus("undef_cmd", 1'b1, 4'd15, 1'b1, 32'hDEAD_BEEF, 32'd7, 1'b1);
      applyStimulus("drain", 1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b1);

      applyStimulus("pre_reset", 1'b1, 4'd8, 1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
      doReset("mid_reset");

      for (int i = 0; i < 400; i++) begin
         cmd = 4'($urandom_range(0, 15));
         if (MUL_EN && cmd == 4'd10) cmd = 4'd2;
         a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom();
         b = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom();
         applyStimulus("rand", $urandom_range(0, 3) != 0, cmd, 1'($urandom_range(0, 1)),
                       a, b, $urandom_range(0, 9) < 7);
      end
      applyStimulus("rand_drain", 1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b1);

`ifdef ALU_MUL_EN
      applyStimulus("mul_accept", 1'b1, 4'd10, 1'b1, 32'h0000_FFFF, 32'h0001_0001, 1'b1);
      n = 0;
      while (!bus.out_valid && n < 100) begin
         applyStimulus("mul_run", 1'b1, 4'd2, 1'b0, $urandom(), $urandom(), 1'b1);
         n++;
      end
      compare("mul.latency", 64'(n), 64'd33);
      compare("mul.res_const", 64'(bus.alu_res), 64'hFFFF_FFFF);
      compare("mul.n_flag", 64'(bus.res_flags[3]), 64'd1);
      applyStimulus("mul_drain", 1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b1);

      applyStimulus("mul2_accept", 1'b1, 4'd10, 1'b1, 32'h0000_FFFF, 32'h0001_0001, 1'b1);
      for (int i = 0; i < 9; i++)
         applyStimulus("mul2_run", 1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b1);
      doReset("mul2_reset");
      for (int i = 0; i < 40; i++)
         applyStimulus("mul2_after", 1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b1);
`else
      n = 0;
      applyStimulus("cmd10_undef", 1'b1, 4'd10, 1'b1, 32'h0000_FFFF, 32'h0001_0001, 1'b1);
      compare("cmd10.res_const", 64'(bus.alu_res), 64'd0 + 64'(n));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/pipelined_flag_alu.md
Name: pipelined_flag_alu

Overview:
- Parametrised, registered successor to the combinational execute-stage ALU.
- Keeps the same 4-bit EXE_CMD encoding: MOV=1, ADD=2, ADC=3, SUB=4, SBC=5, AND=6, ORR=7, EOR=8, MVN=9.
- Adds an architectural NZCV status register with S-bit-controlled update and ARM-correct carry/overflow.
- Adds valid/ready handshakes on input and output, plus an optional iterative multiplier.
- Sits between the ID/EX pipeline register and EX/MEM.

Parameters:
- WIDTH, 32, datapath width in bits (legal range 8..64).
- RESET_FLAGS, 4'b0000, NZCV value loaded on reset.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation presented
- in_ready  output  1  block can accept an operation this cycle
- exe_cmd  input  4  operation code (encoding above; 10=MUL)
- s_bit  input  1  1 = operation updates status register
- val1  input  WIDTH  operand 1
- val2  input  WIDTH  operand 2
- out_valid  output  1  alu_res/res_flags hold a result
- out_ready  input  1  downstream accepts result
- alu_res  output  WIDTH  registered result
- res_flags  output  4  NZCV computed for this result, whether or not committed
- status_bits  output  4  architectural NZCV register, {N,Z,C,V}
- busy  output  1  multi-cycle operation in progress

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, alu_res=0, res_flags=0, status_bits=RESET_FLAGS, busy=0.
  - FSM goes to IDLE and any in-flight MUL is discarded.
- Handshake:
  - An operation is accepted on a rising edge where in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - A result is consumed on a rising edge where out_valid && out_ready.
  - Consume and accept in the same cycle is allowed, giving full throughput of 1 op/cycle for single-cycle ops.
- Output stability: while out_valid && !out_ready, alu_res, res_flags and out_valid hold unchanged.
- Single-cycle ops (1-9, undefined): result is registered on the accept edge; out_valid=1 from the next cycle (latency 1).
- Arithmetic is done in WIDTH+1 bits, and carry is the bit WIDTH carry-out:
  - ADD = a+b, C=carry.
  - ADC = a+b+C.
  - SUB = a+~b+1, C=1 means no borrow.
  - SBC = a+~b+C.
  - Overflow: V = (a[W-1]==b'[W-1]) && (res[W-1]!=a[W-1]), where b' is the operand actually added (val2 or ~val2).
- Logical/move ops:
  - MOV=val2, MVN=~val2, AND, ORR, EOR.
  - res_flags C and V equal the current status C and V.
- Flag rules:
  - N = res[W-1] and Z = (res==0) for all ops.
  - Status register is written on the same edge as alu_res, only if s_bit=1 and the op is defined.
  - Arithmetic ops update NZCV; logical/move ops and MUL update NZ only and retain C,V.
- Carry-in: ADC/SBC use status C as it stands at the accept edge. Back-to-back accepts see the previous op's committed C, so there is no hazard.
- Undefined cmds (0, 11-15, and 10 when MUL is disabled): alu_res=0, res_flags=0, status unchanged, handshake completes normally.
- FSM states IDLE, MUL, DONE:
  - IDLE -> MUL on accept of cmd 10.
  - MUL runs WIDTH cycles of shift-add (one multiplier bit per cycle, LSB first) with a WIDTH-bit counter.
  - MUL -> DONE when counter reaches WIDTH-1.
  - DONE writes the low WIDTH bits of the product and the flags, sets out_valid, and returns to IDLE.
  - MUL latency is WIDTH+1 cycles from accept to out_valid.
  - busy=1 in MUL and DONE; in_ready=0 throughout.
- MUL operand corner cases:
  - Operands are latched at accept; input changes during MUL are ignored.
  - Product of 0 or operand 0 still takes the full WIDTH+1 cycles (no early exit).

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: cmd 10 = unsigned iterative multiply (low WIDTH bits) with the MUL/DONE states as above.
- Undefined: no multiplier datapath, counter or MUL/DONE states are built. cmd 10 is treated as undefined (single-cycle, result 0, status unchanged), and busy is tied to 0.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> out_valid=0, alu_res=0, status_bits=0000, in_ready=1 immediately (asynchronous).
- ADD, WIDTH=32, 0x7FFFFFFF+0x00000001, s_bit=1 -> next cycle alu_res=0x80000000, status_bits=1001.
- SUB 5-5, s_bit=1 -> alu_res=0, status_bits=0110. Then ADC 1+1, s_bit=0 -> alu_res=3, status_bits unchanged at 0110.
- MVN 0x0 with s_bit=1 after SUB 0-1 (NZCV=1000) -> alu_res=0xFFFFFFFF, status_bits=1000. Confirms C,V retained through a logical op.
- Backpressure: out_ready=0, issue ADD 1+2 then ORR 4|8 -> first result 3 held stable, in_ready=0, ORR not accepted. Raise out_ready -> 3 consumed, ORR accepted same cycle, 12 appears next cycle.
- ALU_MUL_EN, WIDTH=32:
  - 0x0000FFFF*0x00010001 -> out_valid exactly 33 cycles after accept, alu_res=0xFFFFFFFF, N=1, busy/in_ready correct throughout.
  - Repeat with rst_n pulsed at cycle 10 -> no result emitted, FSM back in IDLE.
